// File: rtl/mem_fifo_pkg.sv
// Shared widths, word/count types and the sticky error flag bundle for the FIFO read adapter.
package mem_fifo_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef struct packed {
    logic overflow;
    logic spurious;
    logic missing;
  } err_flags_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Circular skid buffer, head is the stored entry at rd_ptr (zero-latency pop).
// No internal backpressure: the producer reserves a slot before pushing; clr empties it.
module fifo_skid_buf #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 2,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clk_en) begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Upstream credit accounting guarantees a free slot for every push.
  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    (clk_en && push && !clr) |-> (count_q < CW'(DEPTH)));

endmodule

// File: rtl/mem_fifo_read_adapter.sv
// Reads memory_core in FIFO mode: tracks stored words, issues credited reads, skids the RD_LAT return.
// Output is valid/ready; reads stall when skid entries plus in-flight reads would exceed SKID_DEPTH.
module mem_fifo_read_adapter #(
  parameter int DATA_W     = mem_fifo_pkg::DATA_W,
  parameter int CNT_W      = mem_fifo_pkg::CNT_W,
  parameter int RD_LAT     = 1,
  parameter int SKID_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              flush,
  input  logic [CNT_W-1:0]  depth,
  input  logic              wen_in,
  output logic              ren_out,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  occupancy,
  output logic              core_full,
  output logic              core_empty,
  output logic              overflow_err,
  output logic              spurious_err,
  output logic              missing_err
);
  import mem_fifo_pkg::*;

  localparam int SKID_CW = $clog2(SKID_DEPTH + 1);

  logic [CNT_W-1:0]   occ_q, occ_d;
  logic [RD_LAT-1:0]  pipe_q, pipe_d;
  err_flags_t         err_q, err_d;
  logic [SKID_CW-1:0] skid_count;
  logic               due, pop, push, credit_ok, wr_acc, ren;
  int                 inflight;

  assign due        = pipe_q[RD_LAT-1];
  assign out_valid  = (skid_count != '0);
  assign pop        = out_valid & out_ready;
  assign push       = !flush & due & valid_in;
  assign core_full  = (occ_q == depth);
  assign core_empty = (occ_q == '0);

  always_comb begin
    inflight  = $countones(pipe_q);
    // Every in-flight read already owns a skid slot, so a returning word always fits.
    credit_ok = (int'(skid_count) + inflight - int'(pop)) < SKID_DEPTH;
    ren       = clk_en & !flush & !core_empty & credit_ok;
    wr_acc    = wen_in & !core_full;

    occ_d = occ_q;
    if (flush)             occ_d = '0;
    else if (wr_acc && !ren) occ_d = occ_q + CNT_W'(1);
    else if (!wr_acc && ren) occ_d = occ_q - CNT_W'(1);

    pipe_d = flush ? '0 : ((pipe_q << 1) | RD_LAT'(ren));

    err_d          = err_q;
    err_d.overflow = err_q.overflow | (wen_in & core_full);
    err_d.missing  = err_q.missing  | (due & !valid_in);
    err_d.spurious = err_q.spurious | (!due & valid_in);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q  <= '0;
      pipe_q <= '0;
      err_q  <= '0;
    end else if (clk_en) begin
      occ_q  <= occ_d;
      pipe_q <= pipe_d;
      err_q  <= err_d;
    end
  end

  fifo_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_DEPTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .clr       (flush),
    .push      (push),
    .push_data (data_in),
    .pop       (pop),
    .count     (skid_count),
    .head      (out_data)
  );

  assign ren_out      = ren;
  assign occupancy    = occ_q;
  assign overflow_err = err_q.overflow;
  assign spurious_err = err_q.spurious;
  assign missing_err  = err_q.missing;

  a_occ_le_depth: assert property (@(posedge clk) disable iff (reset) occ_q <= depth);

endmodule

// File: tb/tb_mem_fifo_read_adapter.sv
// Directed bench for mem_fifo_read_adapter with a one-cycle-latency core model in front of it.
module tb_mem_fifo_read_adapter;
  import mem_fifo_pkg::*;

  logic  clk = 1'b0;
  logic  reset, clk_en, flush;
  cnt_t  depth;
  logic  wen_in, ren_out, valid_in;
  data_t data_in, out_data;
  logic  out_valid, out_ready;
  cnt_t  occupancy;
  logic  core_full, core_empty, overflow_err, spurious_err, missing_err;

  int    n_cmp = 0;
  int    n_bad = 0;
  data_t core_mem[$];
  data_t got[$];
  bit    rd_pend, kill_valid, inject_valid;
  logic  ren_s, ov_s;
  data_t od_s;

  always #5 clk = ~clk;

  mem_fifo_read_adapter dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .flush        (flush),
    .depth        (depth),
    .wen_in       (wen_in),
    .ren_out      (ren_out),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .occupancy    (occupancy),
    .core_full    (core_full),
    .core_empty   (core_empty),
    .overflow_err (overflow_err),
    .spurious_err (spurious_err),
    .missing_err  (missing_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset(input cnt_t dep);
    reset = 1'b1; clk_en = 1'b1; flush = 1'b0; wen_in = 1'b0;
    valid_in = 1'b0; data_in = '0; out_ready = 1'b0; depth = dep;
    kill_valid = 1'b0; inject_valid = 1'b0; rd_pend = 1'b0;
    core_mem.delete(); got.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One clock cycle, entered and left 1 time unit after a rising edge.
  task automatic cyc(input bit w, input data_t wd);
    wen_in = w;
    if (w && clk_en) core_mem.push_back(wd);
    valid_in = (rd_pend && !kill_valid) || inject_valid;
    data_in  = (rd_pend && core_mem.size() > 0) ? core_mem[0] : 16'hDEAD;
    #4;
    ren_s = ren_out;
    ov_s  = out_valid;
    od_s  = out_data;
    if (clk_en && !flush && out_valid && out_ready) got.push_back(out_data);
    if (clk_en) begin
      if (rd_pend && core_mem.size() > 0) void'(core_mem.pop_front());
      rd_pend = ren_out;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rc, rf, rl, oc, of, ol;

    // Reset state
    do_reset(16'd8);
    chk("rst_occ", occupancy, 0);
    chk("rst_empty", core_empty, 1);
    chk("rst_full", core_full, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_ren", ren_out, 0);
    chk("rst_errs", {overflow_err, spurious_err, missing_err}, 0);

    // Basic latency: write at 0, read at 1, core returns at 2, visible at 3
    out_ready = 1'b1;
    cyc(1'b1, 16'h00AB);
    chk("bl_ren0", ren_s, 0);
    chk("bl_occ1", occupancy, 1);
    cyc(1'b0, '0);
    chk("bl_ren1", ren_s, 1);
    chk("bl_occ0", occupancy, 0);
    cyc(1'b0, '0);
    chk("bl_ov2", ov_s, 0);
    cyc(1'b0, '0);
    chk("bl_ov3", ov_s, 1);
    chk("bl_dat3", od_s, 16'h00AB);
    cyc(1'b0, '0);
    chk("bl_ov4", ov_s, 0);

    // Streaming 1..8 with out_ready held high
    do_reset(16'd8);
    out_ready = 1'b1;
    rc = 0; rf = -1; rl = -1; oc = 0; of = -1; ol = -1;
    for (int c = 0; c < 14; c++) begin
      cyc(c < 8, data_t'(c + 1));
      if (ren_s) begin rc++; if (rf < 0) rf = c; rl = c; end
      if (ov_s)  begin oc++; if (of < 0) of = c; ol = c; end
    end
    chk("st_ren_cnt", rc, 8);
    chk("st_ren_first", rf, 1);
    chk("st_ren_span", rl - rf, 7);
    chk("st_ov_cnt", oc, 8);
    chk("st_ov_span", ol - of, 7);
    chk("st_nout", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("st_data", got[i], i + 1);
    chk("st_errs", {overflow_err, spurious_err, missing_err}, 0);

    // Backpressure: 6 writes, consumer stalled for 10 cycles
    do_reset(16'd8);
    rc = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(c < 6, data_t'(16'h0011 + c));
      if (ren_s) rc++;
    end
    chk("bp_reads", rc, 2);
    chk("bp_occ", occupancy, 4);
    chk("bp_ovalid", out_valid, 1);
    chk("bp_head", out_data, 16'h0011);
    chk("bp_errs", {overflow_err, spurious_err, missing_err}, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) cyc(1'b0, '0);
    chk("bp_nout", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk("bp_data", got[i], 16'h0011 + i);
    chk("bp_occ_end", occupancy, 0);
    chk("bp_errs_end", {overflow_err, spurious_err, missing_err}, 0);

    // Overflow at depth 4 with reads blocked by a full skid buffer
    do_reset(16'd4);
    cyc(1'b1, 16'h0021);
    cyc(1'b1, 16'h0022);
    repeat (4) cyc(1'b0, '0);
    chk("of_pre_occ", occupancy, 0);
    chk("of_pre_ov", out_valid, 1);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b1, data_t'(16'h0030 + k));
      if (k == 3) chk("of_full3", core_full, 0);
      if (k == 4) begin
        chk("of_full4", core_full, 1);
        chk("of_occ4", occupancy, 4);
        chk("of_err4", overflow_err, 0);
      end
    end
    chk("of_err5", overflow_err, 1);
    chk("of_occ5", occupancy, 4);

    // Missing return on a due read
    do_reset(16'd8);
    out_ready = 1'b1;
    cyc(1'b1, 16'h0055);
    cyc(1'b0, '0);
    chk("mi_ren", ren_s, 1);
    kill_valid = 1'b1;
    cyc(1'b0, '0);
    kill_valid = 1'b0;
    chk("mi_err", missing_err, 1);
    chk("mi_spur", spurious_err, 0);
    cyc(1'b0, '0);
    cyc(1'b0, '0);
    chk("mi_skid", ov_s, 0);
    chk("mi_nout", got.size(), 0);

    // Spurious return with nothing in flight
    do_reset(16'd8);
    inject_valid = 1'b1;
    cyc(1'b0, '0);
    inject_valid = 1'b0;
    chk("sp_err", spurious_err, 1);
    chk("sp_miss", missing_err, 0);
    cyc(1'b0, '0);
    chk("sp_ov", ov_s, 0);

    // clk_en freeze, then flush with 3 words pending, then reset
    do_reset(16'd8);
    for (int c = 0; c < 5; c++) cyc(1'b1, data_t'(16'h0041 + c));
    chk("fc_occ_pre", occupancy, 3);
    clk_en = 1'b0; out_ready = 1'b1; inject_valid = 1'b1;
    rc = 0;
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, 16'h0099);
      if (ren_s) rc++;
    end
    clk_en = 1'b1; out_ready = 1'b0; inject_valid = 1'b0;
    chk("fc_frz_ren", rc, 0);
    chk("fc_frz_occ", occupancy, 3);
    chk("fc_frz_head", out_data, 16'h0041);
    chk("fc_frz_ov", out_valid, 1);
    chk("fc_frz_errs", {overflow_err, spurious_err, missing_err}, 0);
    inject_valid = 1'b1;
    cyc(1'b0, '0);
    inject_valid = 1'b0;
    chk("fc_spur", spurious_err, 1);
    flush = 1'b1; out_ready = 1'b1;
    cyc(1'b0, '0);
    flush = 1'b0; out_ready = 1'b0;
    chk("fc_fl_ren", ren_s, 0);
    chk("fc_fl_occ", occupancy, 0);
    chk("fc_fl_ov", out_valid, 0);
    chk("fc_fl_empty", core_empty, 1);
    chk("fc_fl_err", spurious_err, 1);
    do_reset(16'd8);
    chk("fc_rst_err", {overflow_err, spurious_err, missing_err}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
